// File: rtl/mips_mem_pkg.sv
// Shared encodings for the load/store unit.
// Access sizes, FSM states and the alignment rule.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_e;

    // A request is bad if it is illegal or crosses its natural alignment.
    function automatic logic misaligned(size_e size, logic [1:0] off);
        logic bad;
        bad = 1'b0;
        unique case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = off[0];
            SIZE_WORD: bad = (off != 2'b00);
            SIZE_ILL:  bad = 1'b1;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/half lane extraction with extension for loads,
// and lane merge of new store data into an old word.
module lsu_lane_align
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic [15:0]           wdata_i,
    input  size_e                 size_i,
    input  logic [1:0]            off_i,
    input  logic                  unsigned_i,
    output logic [DATA_WIDTH-1:0] load_o,
    output logic [DATA_WIDTH-1:0] merge_o
);

    logic [7:0]  b_lane;
    logic [15:0] h_lane;

    // Little-endian lane pick, extend for loads, replace lanes for stores.
    always_comb begin
        b_lane  = word_i[{off_i, 3'b000} +: 8];
        h_lane  = word_i[{off_i[1], 4'b0000} +: 16];
        load_o  = word_i;
        merge_o = word_i;
        unique case (size_i)
            SIZE_BYTE: begin
                load_o = {{(DATA_WIDTH-8){b_lane[7] & ~unsigned_i}}, b_lane};
                merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SIZE_HALF: begin
                load_o = {{(DATA_WIDTH-16){h_lane[15] & ~unsigned_i}}, h_lane};
                merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i;
            end
            SIZE_WORD: ;
            SIZE_ILL:  ;
            default:   ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time against a word-indexed memory.
// Sub-word stores are done as read-modify-write.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    state_e                state_q;
    size_e                 size_q;
    logic [1:0]            off_q;
    logic                  we_q;
    logic                  uns_q;
    logic [15:0]           wdata_q;
    logic                  resp_valid_q;
    logic                  resp_err_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;
    logic [DATA_WIDTH-1:0] mem_address_q;
    logic [DATA_WIDTH-1:0] mem_wd_q;
    logic                  mem_we_q;
    logic                  mem_re_q;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merge_data;
    size_e                 req_size_e;

    assign req_size_e  = size_e'(req_size);
    assign req_ready   = (state_q == IDLE) && !rst;
    assign resp_valid  = resp_valid_q;
    assign resp_err    = resp_err_q;
    assign resp_rdata  = resp_rdata_q;
    assign mem_address = mem_address_q;
    assign mem_wd      = mem_wd_q;
    assign mem_we      = mem_we_q;
    assign mem_re      = mem_re_q;

    lsu_lane_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_align (
        .word_i    (mem_rd),
        .wdata_i   (wdata_q),
        .size_i    (size_q),
        .off_i     (off_q),
        .unsigned_i(uns_q),
        .load_o    (load_data),
        .merge_o   (merge_data)
    );

    // Request FSM; memory strobes are registered so they align with states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            size_q        <= SIZE_BYTE;
            off_q         <= 2'b00;
            we_q          <= 1'b0;
            uns_q         <= 1'b0;
            wdata_q       <= '0;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_rdata_q  <= '0;
            mem_address_q <= '0;
            mem_wd_q      <= '0;
            mem_we_q      <= 1'b0;
            mem_re_q      <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        size_q        <= req_size_e;
                        off_q         <= req_addr[1:0];
                        we_q          <= req_we;
                        uns_q         <= req_unsigned;
                        wdata_q       <= req_wdata[15:0];
                        mem_address_q <= DATA_WIDTH'(req_addr[ADDR_WIDTH-1:2]);
                        if (misaligned(req_size_e, req_addr[1:0])) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else if (req_we && req_size_e == SIZE_WORD) begin
                            state_q  <= WRITE;
                            mem_we_q <= 1'b1;
                            mem_wd_q <= req_wdata;
                        end else begin
                            state_q  <= READ;
                            mem_re_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (we_q) begin
                        state_q  <= WRITE;
                        mem_we_q <= 1'b1;
                        mem_wd_q <= merge_data;
                    end else begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= load_data;
                    end
                end
                WRITE: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases,
// then random requests against a byte-arithmetic memory model.
module tb_load_store_unit;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rd;

    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    logic        preload = 1'b1;
    int          we_cnt = 0;
    int          re_cnt = 0;
    int          nvec = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_address(mem_address), .mem_wd(mem_wd),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rd(mem_rd)
    );

    assign mem_rd = mem[mem_address[3:0]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= ref_mem[i];
        end else begin
            if (mem_we) begin
                mem[mem_address[3:0]] <= mem_wd;
                we_cnt <= we_cnt + 1;
            end
            if (mem_re) re_cnt <= re_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_bad(int sz, int a);
        return sz == 3 || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0);
    endfunction

    function automatic logic [31:0] ref_mask(int sz);
        if (sz == 0) return 32'h0000_00FF;
        if (sz == 1) return 32'h0000_FFFF;
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] w, int sz, int a,
                                             bit uns);
        logic [31:0] v;
        v = (w >> ((a % 4) * 8)) & ref_mask(sz);
        if (!uns && sz == 0 && v >= 32'h80) v = v + 32'hFFFF_FF00;
        if (!uns && sz == 1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
        return v;
    endfunction

    function automatic logic [31:0] ref_store(logic [31:0] w, int sz, int a,
                                              logic [31:0] d);
        logic [31:0] m;
        m = ref_mask(sz) << ((a % 4) * 8);
        return (w & ~m) | ((d << ((a % 4) * 8)) & m);
    endfunction

    // One full transaction, checked against the model; returns what was seen.
    task automatic do_req(input bit we, input int sz, input bit uns,
                          input int addr, input logic [31:0] wd,
                          input int hold,
                          output logic [31:0] rd_o, output logic err_o);
        int n, lat, w0, r0, exp_lat, exp_we, exp_re;
        bit bad;
        logic [31:0] exp_rd, held;
        bad = ref_bad(sz, addr);
        exp_rd = (bad || we) ? 32'h0 :
                 ref_load(ref_mem[addr / 4], sz, addr, uns);
        exp_lat = bad ? 1 : (!we ? 2 : (sz == 2 ? 2 : 3));
        exp_we = (!bad && we) ? 1 : 0;
        exp_re = (!bad && (!we || sz != 2)) ? 1 : 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = 2'(sz);
        req_unsigned = uns; req_addr = addr; req_wdata = wd;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk); n++;
        end
        chk("accept_timeout", 32'(n < 20), 32'd1);
        w0 = we_cnt; r0 = re_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk); lat++;
        end while (resp_valid !== 1'b1 && lat < 10);
        chk("latency", lat, exp_lat);
        chk("resp_err", 32'(resp_err), 32'(bad));
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("we_pulses", we_cnt - w0, exp_we);
        chk("re_pulses", re_cnt - r0, exp_re);
        rd_o = resp_rdata; err_o = resp_err;
        held = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_ready", 32'(req_ready), 32'd0);
            chk("hold_rdata", resp_rdata, held);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk("post_valid", 32'(resp_valid), 32'd0);
        chk("post_ready", 32'(req_ready), 32'd1);
        chk("we_total", we_cnt - w0, exp_we);
        if (!bad && we)
            ref_mem[addr / 4] = ref_store(ref_mem[addr / 4], sz, addr, wd);
        chk("mem_word", mem[addr / 4], ref_mem[addr / 4]);
    endtask

    initial begin
        logic [31:0] rd, w2;
        logic        er;
        int          w0;
        for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
        ref_mem[0] = 32'h8000_00F0;
        ref_mem[1] = 32'h1122_3344;
        rst = 1'b1;
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_re", 32'(mem_re), 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        repeat (3) @(negedge clk);
        preload = 1'b0;
        rst = 1'b0;
        #1;
        chk("idle_req_ready", 32'(req_ready), 32'd1);

        do_req(1'b0, 0, 1'b0, 32'h0, 32'h0, 0, rd, er);
        chk("lb_signed", rd, 32'hFFFF_FFF0);
        do_req(1'b0, 1, 1'b1, 32'h2, 32'h0, 1, rd, er);
        chk("lhu_hi", rd, 32'h0000_8000);
        do_req(1'b1, 0, 1'b0, 32'h5, 32'h0000_00AB, 0, rd, er);
        chk("sb_word1", mem[1], 32'h1122_AB44);
        do_req(1'b0, 2, 1'b0, 32'h6, 32'h0, 0, rd, er);
        chk("lw_mis_err", 32'(er), 32'd1);
        chk("lw_mis_rdata", rd, 32'd0);
        do_req(1'b1, 2, 1'b0, 32'h8, 32'hDEAD_BEEF, 3, rd, er);
        chk("sw_word2", mem[2], 32'hDEAD_BEEF);
        chk("sw_rdata", rd, 32'd0);

        // Reset during the READ phase of a byte store.
        w2 = mem[2];
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00;
        req_addr = 32'h9; req_wdata = 32'h55;
        w0 = we_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rmw_read_re", 32'(mem_re), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_state", 32'(dut.state_q), 32'(IDLE));
        chk("mid_req_ready", 32'(req_ready), 32'd0);
        chk("mid_mem_re", 32'(mem_re), 32'd0);
        chk("mid_mem_we", 32'(mem_we), 32'd0);
        chk("mid_resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_mem_address", mem_address, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_no_write", we_cnt - w0, 32'd0);
        chk("mid_mem_kept", mem[2], w2);
        chk("mid_no_resp", 32'(resp_valid), 32'd0);
        chk("mid_ready_back", 32'(req_ready), 32'd1);

        for (int t = 0; t < 60; t++) begin
            do_req(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                   $urandom, int'($urandom_range(0, 2)), rd, er);
        end

        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width of the data path and the memory.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk input 1 rising-edge clock; rst input 1 asynchronous active-high reset.
REQ-004 SHALL have req_valid input 1: request present.
REQ-005 SHALL have req_ready output 1: request accepted when high with req_valid.
REQ-006 SHALL have req_we input 1: 1 store, 0 load.
REQ-007 SHALL have req_size input 2: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have req_unsigned input 1: zero-extend loads when 1, sign-extend when 0.
REQ-009 SHALL have req_addr input ADDR_WIDTH: byte address.
REQ-010 SHALL have req_wdata input DATA_WIDTH: store data, right-aligned.
REQ-011 SHALL have resp_valid output 1, resp_ready input 1, resp_rdata output DATA_WIDTH and resp_err output 1: completion handshake, extended load data, and misaligned/illegal flag.
REQ-012 SHALL have mem_address output DATA_WIDTH: word index to the data memory.
REQ-013 SHALL have mem_wd output DATA_WIDTH, mem_we output 1, mem_re output 1, and mem_rd input DATA_WIDTH: memory write data, write enable, read enable, and combinational read data.

Function
REQ-014 SHALL use the FSM states IDLE, READ, WRITE and RESP.
REQ-015 SHALL assert req_ready only in IDLE, and SHALL capture addr, size, we, unsigned and wdata on a req_valid&&req_ready edge.
REQ-016 SHALL drive mem_address = {2'b00, addr[ADDR_WIDTH-1:2]} from the captured address; memory is word-indexed.
REQ-017 SHALL treat a request as misaligned if size=01 && addr[0], size=10 && addr[1:0]!=0, or size=11; such a request goes IDLE->RESP with resp_err=1 and resp_rdata=0, and mem_we/mem_re stay 0.
REQ-018 SHALL handle a load as IDLE->READ->RESP: in READ, mem_re=1 and mem_rd is registered; total latency from accept to resp_valid is 2 cycles.
REQ-019 SHALL, on a load, select the byte or half indexed by addr[1:0] (little-endian) and sign- or zero-extend it per req_unsigned; a word load returns mem_rd unchanged.
REQ-020 SHALL handle a word store as IDLE->WRITE->RESP: in WRITE, mem_we=1 and mem_wd=wdata; the write commits at the end of WRITE.
REQ-021 SHALL handle a byte/half store as read-modify-write, IDLE->READ->WRITE->RESP: READ captures the old word; WRITE drives it with only the addressed lane(s) replaced by wdata[7:0] or wdata[15:0].
REQ-022 SHALL return resp_rdata=0 on a store response.
REQ-023 SHALL, in RESP, hold resp_valid=1 and all resp_* stable until resp_ready; on resp_valid&&resp_ready it returns to IDLE (no same-cycle new accept; next accept earliest the following cycle).
REQ-024 SHALL hold mem_we=0 and mem_re=0 outside WRITE and READ respectively; mem_we SHALL never be high for more than one cycle per request.

Reset
REQ-025 SHALL, while rst=1, asynchronously force state IDLE, req_ready=0 for the cycle rst is high (1 thereafter in IDLE), resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_re=0, mem_address=0 and mem_wd=0.
REQ-026 SHALL discard an in-flight request on reset mid-operation: no write issued after rst asserts, and no response produced.

Structure
REQ-027 SHALL place size encodings (SIZE_BYTE/HALF/WORD) and state encodings in shared package mips_mem_pkg.
REQ-028 SHALL implement lane extract/extend and lane merge in one combinational sub-module, lsu_lane_align.

Verification
REQ-029 SHALL cover: mem word0=0x8000_00F0, load byte addr 0x0 signed -> resp_rdata=0xFFFF_FFF0 two cycles after accept, resp_err=0.
REQ-030 SHALL cover: same word, load half addr 0x2 unsigned -> resp_rdata=0x0000_8000.
REQ-031 SHALL cover: word1=0x1122_3344, store byte 0xAB to addr 0x5 -> one mem_we pulse, word1=0x1122_AB44.
REQ-032 SHALL cover: load word addr 0x6 -> resp_err=1, resp_rdata=0, mem_re/mem_we never asserted.
REQ-033 SHALL cover: store word 0xDEAD_BEEF to addr 0x8 with resp_ready held 0 for 3 cycles -> resp_valid held, req_ready=0, word2=0xDEAD_BEEF, single write.
REQ-034 SHALL cover: assert rst during READ of a byte store -> state IDLE, no mem_we, memory unchanged, resp_valid=0.
